// File: rtl/survival_timer_ctrl.sv
`default_nettype none
// ============================================================================
// survival_timer_ctrl : BCD survival countdown and lives/hit-cooldown tracker
// Revision: 1.0
// ============================================================================
module survival_timer_ctrl #(
   parameter int SURVIVAL_SECONDS    = 60,
   parameter int LIVES               = 3,
   parameter int HIT_COOLDOWN_FRAMES = 30
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startGame,
   input  logic       oneSecPulse,
   input  logic       startOfFrame,
   input  logic       collision,
   output logic       tc,
   output logic       gameOver,
   output logic [3:0] timeTens,
   output logic [3:0] timeOnes,
   output logic [2:0] livesLeft,
   output logic       invulnerable
);

   localparam logic [3:0] C_TENS  = 4'(SURVIVAL_SECONDS / 10);
   localparam logic [3:0] C_ONES  = 4'(SURVIVAL_SECONDS % 10);
   localparam logic [2:0] C_LIVES = 3'(LIVES);
   localparam logic [7:0] C_COOL  = 8'(HIT_COOLDOWN_FRAMES);

   typedef enum logic [1:0] {
      s_idle = 2'd0,
      s_run  = 2'd1,
      s_done = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic [2:0] lives_q, lives_d;
   logic [7:0] cool_q, cool_d;
   logic       tc_q, tc_d;
   logic       go_q, go_d;
   logic       inv_q, inv_d;
   logic       coll_q;

   logic       w_run;
   logic       w_hit;
   logic       w_fatal;
   logic       w_expire;

   assign w_run    = (state_q == s_run);
   assign w_hit    = w_run && collision && !coll_q && (cool_q == 8'd0);
   assign w_fatal  = w_hit && (lives_q <= 3'd1);
   assign w_expire = w_run && oneSecPulse && (tens_q == 4'd0) && (ones_q == 4'd0);

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      lives_d = lives_q;
      cool_d  = cool_q;
      tc_d    = tc_q;
      go_d    = go_q;

      case (state_q)
         s_idle: begin
            if (startGame) begin
               state_d = s_run;
            end
         end
         s_run: begin
            if (oneSecPulse && !w_expire) begin
               if (ones_q == 4'd0) begin
                  ones_d = 4'd9;
                  tens_d = tens_q - 4'd1;
               end else begin
                  ones_d = ones_q - 4'd1;
               end
            end
            if (startOfFrame && (cool_q != 8'd0)) begin
               cool_d = cool_q - 8'd1;
            end
            // A hit's cooldown load overrides the frame decrement above.
            if (w_hit) begin
               if (w_fatal) begin
                  lives_d = 3'd0;
                  go_d    = 1'b1;
                  state_d = s_done;
               end else begin
                  lives_d = lives_q - 3'd1;
                  cool_d  = C_COOL;
               end
            end
            if (w_expire && !w_fatal) begin
               tc_d    = 1'b1;
               state_d = s_done;
            end
         end
         s_done: begin
            state_d = s_done;
         end
         default: begin
            state_d = s_idle;
         end
      endcase

      inv_d = (cool_d != 8'd0);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= s_idle;
         tens_q  <= C_TENS;
         ones_q  <= C_ONES;
         lives_q <= C_LIVES;
         cool_q  <= 8'd0;
         tc_q    <= 1'b0;
         go_q    <= 1'b0;
         inv_q   <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         lives_q <= lives_d;
         cool_q  <= cool_d;
         tc_q    <= tc_d;
         go_q    <= go_d;
         inv_q   <= inv_d;
         coll_q  <= collision;
      end
   end

   assign tc           = tc_q;
   assign gameOver     = go_q;
   assign timeTens     = tens_q;
   assign timeOnes     = ones_q;
   assign livesLeft    = lives_q;
   assign invulnerable = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_survival_timer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_survival_timer_ctrl : directed vector bench for survival_timer_ctrl
// Revision: 1.0
// ============================================================================
module tb_survival_timer_ctrl;

   logic       clk;
   logic       resetN;
   logic       startGame, oneSecPulse, startOfFrame, collision;
   logic       tc, gameOver, invulnerable;
   logic [3:0] timeTens, timeOnes;
   logic [2:0] livesLeft;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      bit       sg, tk, sf, co;
      bit       e_tc, e_go;
      bit [3:0] e_tens, e_ones;
      bit [2:0] e_lives;
      bit       e_inv;
   } vec_t;

   vec_t vq[$];

   survival_timer_ctrl #(
      .SURVIVAL_SECONDS   (12),
      .LIVES              (3),
      .HIT_COOLDOWN_FRAMES(2)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .startGame   (startGame),
      .oneSecPulse (oneSecPulse),
      .startOfFrame(startOfFrame),
      .collision   (collision),
      .tc          (tc),
      .gameOver    (gameOver),
      .timeTens    (timeTens),
      .timeOnes    (timeOnes),
      .livesLeft   (livesLeft),
      .invulnerable(invulnerable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input bit sg, tk, sf, co, e_tc, e_go,
                      input bit [3:0] e_tens, e_ones,
                      input bit [2:0] e_lives, input bit e_inv);
      vec_t v;
      v.sg = sg; v.tk = tk; v.sf = sf; v.co = co;
      v.e_tc = e_tc; v.e_go = e_go; v.e_tens = e_tens; v.e_ones = e_ones;
      v.e_lives = e_lives; v.e_inv = e_inv;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input bit e_tc, e_go,
                      input bit [3:0] e_tens, e_ones,
                      input bit [2:0] e_lives, input bit e_inv);
      n_checks++;
      if (tc === e_tc && gameOver === e_go && timeTens === e_tens &&
          timeOnes === e_ones && livesLeft === e_lives && invulnerable === e_inv) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got tc=%b go=%b time=%0d%0d lives=%0d inv=%b, want tc=%b go=%b time=%0d%0d lives=%0d inv=%b",
                  name, tc, gameOver, timeTens, timeOnes, livesLeft, invulnerable,
                  e_tc, e_go, e_tens, e_ones, e_lives, e_inv);
      end
   endtask

   // One clock of stimulus: drive on the falling edge, release after the rising edge.
   task automatic cyc(input bit sg, tk, sf, co);
      @(negedge clk);
      startGame = sg; oneSecPulse = tk; startOfFrame = sf; collision = co;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetN = 1'b0;
      startGame = 0; oneSecPulse = 0; startOfFrame = 0; collision = 0;
      @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      resetN = 1'b0;
      startGame = 0; oneSecPulse = 0; startOfFrame = 0; collision = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN = 1'b1;

      //  sg tk sf co  tc go tens ones lives inv
      add(0, 0, 0, 0,  0, 0, 1, 2, 3, 0);   // reset state
      add(0, 1, 0, 0,  0, 0, 1, 2, 3, 0);   // tick ignored in idle
      add(0, 0, 0, 1,  0, 0, 1, 2, 3, 0);   // collision ignored in idle
      add(0, 0, 1, 1,  0, 0, 1, 2, 3, 0);
      add(0, 0, 0, 0,  0, 0, 1, 2, 3, 0);
      add(1, 0, 0, 0,  0, 0, 1, 2, 3, 0);   // start
      add(1, 0, 0, 0,  0, 0, 1, 2, 3, 0);   // restart ignored
      add(0, 1, 0, 0,  0, 0, 1, 1, 3, 0);
      add(0, 1, 0, 0,  0, 0, 1, 0, 3, 0);
      add(0, 1, 0, 0,  0, 0, 0, 9, 3, 0);   // BCD borrow
      add(0, 1, 0, 1,  0, 0, 0, 8, 2, 1);   // non-fatal hit plus tick
      add(0, 0, 1, 1,  0, 0, 0, 8, 2, 1);
      add(0, 0, 1, 1,  0, 0, 0, 8, 2, 0);
      add(0, 0, 1, 1,  0, 0, 0, 8, 2, 0);   // held collision does not count
      add(0, 0, 0, 0,  0, 0, 0, 8, 2, 0);
      add(0, 0, 0, 1,  0, 0, 0, 8, 1, 1);   // fresh edge
      add(0, 0, 1, 0,  0, 0, 0, 8, 1, 1);
      add(0, 0, 1, 0,  0, 0, 0, 8, 1, 0);
      for (int i = 7; i >= 0; i--) add(0, 1, 0, 0, 0, 0, 0, 4'(i), 1, 0);
      add(0, 1, 0, 1,  0, 1, 0, 0, 0, 0);   // fatal hit + expiring tick
      add(1, 1, 1, 0,  0, 1, 0, 0, 0, 0);   // frozen
      add(0, 0, 0, 1,  0, 1, 0, 0, 0, 0);

      foreach (vq[i]) begin
         cyc(vq[i].sg, vq[i].tk, vq[i].sf, vq[i].co);
         chk($sformatf("vec%0d", i), vq[i].e_tc, vq[i].e_go, vq[i].e_tens,
             vq[i].e_ones, vq[i].e_lives, vq[i].e_inv);
      end

      // Countdown to expiry from 12 s.
      do_reset();
      chk("rst_A", 0, 0, 1, 2, 3, 0);
      cyc(1, 0, 0, 0);
      for (int t = 1; t <= 12; t++) begin
         cyc(0, 1, 0, 0);
         chk($sformatf("tick%0d", t), 0, 0, 4'((12 - t) / 10), 4'((12 - t) % 10), 3, 0);
      end
      cyc(0, 1, 0, 0);
      chk("expire", 1, 0, 0, 0, 3, 0);
      cyc(0, 1, 0, 0);
      chk("post_expire_tick", 1, 0, 0, 0, 3, 0);
      cyc(0, 0, 0, 1);
      chk("post_expire_hit", 1, 0, 0, 0, 3, 0);

      // Asynchronous reset mid-run at 0,5 with two lives and cooldown active.
      do_reset();
      cyc(1, 0, 0, 0);
      repeat (7) cyc(0, 1, 0, 0);
      chk("at_05", 0, 0, 0, 5, 3, 0);
      cyc(0, 0, 0, 1);
      chk("hit_before_rst", 0, 0, 0, 5, 2, 1);
      @(negedge clk);
      #2 resetN = 1'b0;
      collision = 0;
      #1;
      chk("async_rst", 0, 0, 1, 2, 3, 0);
      @(negedge clk);
      resetN = 1'b1;

      // Fresh run: three hits separated by three frames.
      cyc(1, 0, 0, 0);
      chk("restart", 0, 0, 1, 2, 3, 0);
      cyc(0, 1, 0, 0);
      chk("restart_tick", 0, 0, 1, 1, 3, 0);
      for (int h = 1; h <= 3; h++) begin
         cyc(0, 0, 0, 1);
         chk($sformatf("hit%0d", h), 0, (h == 3), 1, 1, 3'(3 - h), (h != 3));
         cyc(0, 0, 0, 0);
         repeat (3) cyc(0, 0, 1, 0);
      end
      cyc(0, 1, 0, 0);
      chk("gameover_frozen", 0, 1, 1, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed=%0d", n_pass);
      $fatal(1);
   end

endmodule
`default_nettype wire
